// File: rtl/risc32_div_pkg.sv
// Shared constants, result type and helpers for the EX-stage divider.
package risc32_div_pkg;

  localparam int DATA_W = 32;

  // Divider FSM state codes
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Index of the last restoring step (one quotient bit per step)
  localparam logic [4:0] DIV_CNT_MAX = 5'd31;

  // HI/LO result as written back: remainder in hi, quotient in lo
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } div_result_t;

  // Two's-complement negate when neg is set, pass through otherwise
  function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/risc32_div_if.sv
// EX <-> divider handshake bundle. EX is the master, the divider the slave.
interface risc32_div_if;
  import risc32_div_pkg::*;

  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/risc32_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU. One quotient bit per
// clock; the result is {remainder, quotient} for the HI/LO write path.
module risc32_div
  import risc32_div_pkg::*;
(
  input logic         clk,
  input logic         rst,
  risc32_div_if.slave div_if
);

  logic [1:0]          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  // Combined partial-remainder (upper half) / quotient (lower half) shift reg
  logic [2*DATA_W-1:0] dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  div_result_t         result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   op1_mag, op2_mag;
  logic [DATA_W:0]     trial_top;
  logic                trial_ge;
  logic [DATA_W-1:0]   trial_diff;
  logic [2*DATA_W-1:0] step_val;
  div_result_t         final_res;

  // Operand magnitudes; negation only applies to negative signed operands
  assign op1_mag = neg_if(div_if.signed_div_i & div_if.opdata1_i[DATA_W-1], div_if.opdata1_i);
  assign op2_mag = neg_if(div_if.signed_div_i & div_if.opdata2_i[DATA_W-1], div_if.opdata2_i);

  // One restoring step: the top 33 bits after a left shift are exactly
  // dividend_q[63:31]. When the trial succeeds the difference is below the
  // divisor, so a 32-bit subtraction is sufficient.
  assign trial_top  = dividend_q[2*DATA_W-1:DATA_W-1];
  assign trial_ge   = (trial_top >= {1'b0, divisor_q});
  assign trial_diff = trial_top[DATA_W-1:0] - divisor_q;
  assign step_val   = trial_ge ? {trial_diff, dividend_q[DATA_W-2:0], 1'b1}
                               : {dividend_q[2*DATA_W-2:0], 1'b0};

  // Sign fix-up applied to the result of the final step
  always_comb begin
    final_res.hi = neg_if(neg_rem_q,  step_val[2*DATA_W-1:DATA_W]);
    final_res.lo = neg_if(neg_quot_q, step_val[DATA_W-1:0]);
  end

  // Next-state logic for the divider FSM and its datapath registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d = DIV_RESULT_NOT_READY;
        if (div_if.start_i == DIV_START && !div_if.annul_i) begin
          if (div_if.opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, op1_mag};
            divisor_d  = op2_mag;
            neg_quot_d = div_if.signed_div_i &
                         (div_if.opdata1_i[DATA_W-1] ^ div_if.opdata2_i[DATA_W-1]);
            neg_rem_d  = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
          end
        end
      end

      DIV_BY_ZERO: begin
        if (div_if.annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (div_if.annul_i) begin
          state_d = DIV_FREE;
        end else begin
          dividend_d = step_val;
          cnt_d      = cnt_q + 5'd1;
          if (cnt_q == DIV_CNT_MAX) begin
            state_d  = DIV_END;
            result_d = final_res;
            ready_d  = DIV_RESULT_READY;
          end
        end
      end

      DIV_END: begin
        if (div_if.annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else if (div_if.start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: begin
        state_d = DIV_FREE;
        ready_d = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign div_if.result_o   = result_q;
  assign div_if.ready_o    = ready_q;
  assign div_if.stallreq_o = div_if.start_i & ~ready_q;

endmodule

// File: tb/tb_risc32_div.sv
// Directed bench for risc32_div: stimulus pushes expected results into a
// scoreboard queue, a monitor pops and compares on each ready_o rise.
module tb_risc32_div;

  logic clk = 1'b0;
  logic rst = 1'b0;

  risc32_div_if dif();

  risc32_div dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;
  logic        prev_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every new result against the oldest expectation
  always @(negedge clk) begin
    if (dif.ready_o === 1'b1 && prev_ready !== 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: result %h with no operation pending", dif.result_o);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("result", dif.result_o, mon_exp);
        $display("[TB] result %h expected %h", dif.result_o, mon_exp);
      end
    end
    prev_ready = dif.ready_o;
  end

  // Issue one division, check handshake timing, optionally hold and release
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                         input int hold, input bit drop);
    int lat;
    int stall_bad;
    @(negedge clk);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.annul_i      = 1'b0;
    dif.start_i      = 1'b1;
    sb_q.push_back(exp);
    $display("[TB] %s: signed=%0b a=%h b=%h expect %h", name, sgn, a, b, exp);
    #1 chk({name, "_stall_start"}, 64'(dif.stallreq_o), 64'd1);
    lat = 0;
    stall_bad = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // operands must be ignored once the operation is accepted
        dif.opdata1_i    = ~a;
        dif.opdata2_i    = b ^ 32'h5;
        dif.signed_div_i = ~sgn;
      end
      if (dif.ready_o === 1'b1) break;
      if (dif.stallreq_o !== 1'b1) stall_bad++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_stall_hold"}, 64'(stall_bad), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_end_ready"}, 64'(dif.ready_o), 64'd1);
      chk({name, "_end_result"}, dif.result_o, exp);
    end
    if (drop) begin
      dif.start_i = 1'b0;
      #1 chk({name, "_stall_drop"}, 64'(dif.stallreq_o), 64'd0);
      @(negedge clk);
      chk({name, "_free_ready"}, 64'(dif.ready_o), 64'd0);
      chk({name, "_free_result"}, dif.result_o, 64'd0);
    end
  endtask

  initial begin
    int seen;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;

    // Reset state
    #1;
    chk("reset_ready", 64'(dif.ready_o), 64'd0);
    chk("reset_result", dif.result_o, 64'd0);
    chk("reset_stall", 64'(dif.stallreq_o), 64'd0);
    #20 rst = 1'b1;

    run_div("udiv_100_7",   1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                 33, 0, 1'b1);
    run_div("sdiv_m7_2",    1'b1, 32'hFFFFFFF9,   32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 3, 1'b1);
    run_div("sdiv_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},    33, 0, 1'b1);
    run_div("sdiv_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000},    33, 0, 1'b1);
    run_div("udiv_ovf_ops", 1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000},    33, 0, 1'b1);
    run_div("div_by_zero",  1'b0, 32'd5,          32'd0,        64'd0,                           2,  2, 1'b1);

    // Annul during ON: no result may ever appear
    @(negedge clk);
    $display("[TB] annul: a=ffffffff b=00000010 cancelled mid-operation");
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'hFFFFFFFF;
    dif.opdata2_i    = 32'h10;
    dif.start_i      = 1'b1;
    repeat (9) @(negedge clk);
    dif.annul_i = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o !== 1'b0) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);

    run_div("udiv_after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 33, 0, 1'b1);

    // Asynchronous reset while a result is held in END
    run_div("udiv_hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1, 1'b0);
    #2 rst = 1'b0;
    #1;
    $display("[TB] reset asserted while result held");
    chk("rst_end_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_end_result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    $display("[TB] reset asserted mid-operation");
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd1000;
    dif.opdata2_i    = 32'd3;
    dif.start_i      = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_on_ready", 64'(dif.ready_o), 64'd0);
    chk("rst_on_result", dif.result_o, 64'd0);
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o !== 1'b0) seen++;
    end
    chk("rst_idle_ready", 64'(seen), 64'd0);

    run_div("sdiv_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, 0, 1'b1);

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/risc32_div.md
Name: risc32_div

Overview:
Iterative 32-bit signed/unsigned divider serving DIV/DIVU in the EX stage. Produces remainder (HI half) and quotient (LO half) for the HI/LO write path, whose writeback stage drives the HI/LO register write port with this result. Radix-2 restoring algorithm, one quotient bit per clock. Stalls the pipeline via a handshake with EX.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W (fixed at 32 in this CPU).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
opdata1_i  in  32  dividend.
opdata2_i  in  32  divisor.
start_i  in  1  request; held high by EX until ready_o seen.
annul_i  in  1  cancel in-flight operation (flush/exception).
result_o  out  64  {remainder[63:32], quotient[31:0]} = {hi, lo}.
ready_o  out  1  result_o valid.
stallreq_o  out  1  combinational: start_i & ~ready_o.

Behaviour:
- Reset (rst=0, async): state=FREE, result_o=0, ready_o=0, counter=0, internal dividend/divisor regs=0. Takes effect immediately, including mid-operation.
- States: FREE, BY_ZERO, ON, END (encodings are shared constants).
- FREE: ready_o=0. If start_i=1 and annul_i=0: if opdata2_i==0 -> BY_ZERO, else latch operands -> ON, counter=0. For signed_div_i=1, latch absolute values (two's-complement negate when MSB=1) and record sign_q = op1[31]^op2[31], sign_r = op1[31]. Otherwise stay in FREE.
- BY_ZERO: next edge -> END with result_o=0.
- ON: each edge performs one restoring step on 65-bit partial-remainder/quotient shift reg: shift left 1; if upper 33 bits >= {1'b0,divisor}, subtract and set LSB=1. Counter increments 0..31. On the edge where counter==31 completes, apply sign fix (negate quotient if sign_q, negate remainder if sign_r, signed mode only), load result_o, ready_o=1, -> END.
- annul_i=1 in ON or BY_ZERO: next edge -> FREE, ready_o stays 0, result_o unchanged. annul_i in END: -> FREE, ready_o=0.
- END: ready_o=1, result_o held. If start_i=0 next edge -> FREE, ready_o=0, result_o=0. If start_i stays 1, remain in END (no re-issue).
- Latency: counting the accepting edge as edge 1, ready_o rises after edge 33 (nonzero divisor) or edge 2 (zero divisor).
- Operand inputs ignored outside FREE; signed_div_i sampled only at acceptance.
- Overflow 0x80000000 / -1 (signed): quotient wraps to 0x80000000, remainder 0; no trap.
- Unsigned mode: full 32-bit magnitudes, no sign fix.

Decomposition:
- risc32_consts.v: Div_Free, Div_By_Zero, Div_On, Div_End state codes; Div_Result_Ready / Div_Result_Not_Ready; Div_Start / Div_Stop; Div_Cnt_Max (31).
- risc32_instructions.v: DIV/DIVU funct codes (decode lives in ID, not here).
- No sub-module; sign magnitude conversion is inline combinational logic.

Test Plan:
- Unsigned 100/7: start_i=1 -> ready_o high after edge 33, result_o = {32'd2, 32'd14}; stallreq_o high until then.
- Signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned same operands -> {0x80000000, 0x00000000}.
- Divide by zero 5/0 -> ready_o after edge 2, result_o=0; drop start_i -> FREE, ready_o=0 next edge.
- annul_i at edge 10 of ON -> FREE, ready_o never asserts; then unsigned 0xFFFFFFFF/0x10 -> {0x0000000F, 0x0FFFFFFF}.
- rst driven low mid-ON (between edges) -> result_o=0, ready_o=0 immediately; after release, idle in FREE until start_i.
